// File: rtl/service_4_random_led_gen.sv
// Target LED generator for the service-4 minigame: shows one-hot LFSR-drawn targets,
// waits for a switch match or timeout, then enforces a blank gap and a switches-cleared rule.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | alarm FSM not in minigame; all outputs quiet
// WAIT_CLEAR | minigame active, waiting for every switch to be down
// SHOW       | target driven on random_led; waiting for match or timeout
// GAP        | round finished; LEDs blank for GAP_CYCLES before next round
module service_4_random_led_gen #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [15:0] GAP_CYCLES     = 16'd5000,
  parameter logic [9:0]  LFSR_SEED      = 10'h2A5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] alarm_state,
  input  logic [9:0] SPDTs,
  output logic [9:0] random_led,
  output logic       led_valid,
  output logic       hit,
  output logic       timeout,
  output logic [3:0] round_cnt
);

  localparam logic [2:0] ALARM_MINIGAME = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CLEAR,
    SHOW,
    GAP
  } state_t;

  state_t      state;
  logic [9:0]  lfsr;
  logic [3:0]  prev_idx;
  logic [15:0] timer;

  logic [3:0]  raw;
  logic [3:0]  idx0;
  logic [3:0]  idx;
  logic [9:0]  target_onehot;
  logic [3:0]  round_cnt_next;

  // x^10 + x^7 + 1, free-running in every state so targets stay unpredictable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end
  end

  // Fold the nibble into 0..9, then bump past the previous target so rounds never repeat.
  always_comb begin
    raw  = lfsr[3:0];
    idx0 = (raw < 4'd10) ? raw : (raw - 4'd10);
    if (idx0 == prev_idx) begin
      idx = (idx0 == 4'd9) ? 4'd0 : (idx0 + 4'd1);
    end else begin
      idx = idx0;
    end
    target_onehot  = 10'd1 << idx;
    round_cnt_next = (round_cnt == 4'hF) ? 4'hF : (round_cnt + 4'd1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      random_led <= 10'd0;
      led_valid  <= 1'b0;
      hit        <= 1'b0;
      timeout    <= 1'b0;
      round_cnt  <= 4'd0;
      prev_idx   <= 4'hF;
      timer      <= 16'd0;
    end else begin
      hit     <= 1'b0;
      timeout <= 1'b0;
      if (alarm_state != ALARM_MINIGAME) begin
        // Leaving the minigame aborts any round; round_cnt is kept for the alarm FSM to read.
        state      <= IDLE;
        random_led <= 10'd0;
        led_valid  <= 1'b0;
        timer      <= 16'd0;
        prev_idx   <= 4'hF;
      end else begin
        case (state)
          IDLE: begin
            state      <= WAIT_CLEAR;
            round_cnt  <= 4'd0;
            random_led <= 10'd0;
            led_valid  <= 1'b0;
          end
          WAIT_CLEAR: begin
            if (SPDTs == 10'd0) begin
              state      <= SHOW;
              random_led <= target_onehot;
              led_valid  <= 1'b1;
              prev_idx   <= idx;
              timer      <= 16'd0;
            end else begin
              random_led <= 10'd0;
              led_valid  <= 1'b0;
            end
          end
          SHOW: begin
            if (SPDTs == random_led) begin
              hit        <= 1'b1;
              state      <= GAP;
              random_led <= 10'd0;
              led_valid  <= 1'b0;
              timer      <= 16'd0;
              round_cnt  <= round_cnt_next;
            end else if (timer == (TIMEOUT_CYCLES - 16'd1)) begin
              timeout    <= 1'b1;
              state      <= GAP;
              random_led <= 10'd0;
              led_valid  <= 1'b0;
              timer      <= 16'd0;
              round_cnt  <= round_cnt_next;
            end else begin
              timer <= timer + 16'd1;
            end
          end
          GAP: begin
            if (timer == (GAP_CYCLES - 16'd1)) begin
              state <= WAIT_CLEAR;
              timer <= 16'd0;
            end else begin
              timer <= timer + 16'd1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_service_4_random_led_gen.sv
// Directed bench for service_4_random_led_gen with short timeout/gap so every phase is reachable.
module tb_service_4_random_led_gen;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] alarm_state;
  logic [9:0] SPDTs;
  logic [9:0] random_led;
  logic       led_valid;
  logic       hit;
  logic       timeout;
  logic [3:0] round_cnt;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [9:0] prev_target;
  logic [3:0] exp_rounds;

  service_4_random_led_gen #(
    .TIMEOUT_CYCLES(16'd8),
    .GAP_CYCLES    (16'd2),
    .LFSR_SEED     (10'h2A5)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .alarm_state(alarm_state),
    .SPDTs      (SPDTs),
    .random_led (random_led),
    .led_valid  (led_valid),
    .hit        (hit),
    .timeout    (timeout),
    .round_cnt  (round_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn      = 1'b0;
    alarm_state = 3'b000;
    SPDTs       = 10'd0;
    repeat (3) tick();
    tests_run++;
    if (random_led !== 10'd0) begin tests_failed++; $display("FAIL reset_led got %h want 000", random_led); end
    tests_run++;
    if (led_valid !== 1'b0 || hit !== 1'b0 || timeout !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags got v%b h%b t%b want 000", led_valid, hit, timeout);
    end
    tests_run++;
    if (round_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset_rounds got %0d want 0", round_cnt); end
    alarm_state = 3'b010;
    tick();
    tests_run++;
    if (led_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_hold got valid %b want 0", led_valid); end
    resetn = 1'b1;
  endtask

  // Edge 1 -> WAIT_CLEAR, edge 2 -> first target from lfsr 0x14B: raw 11 -> idx 1.
  task automatic test_first_target();
    tick();
    tests_run++;
    if (led_valid !== 1'b0 || random_led !== 10'd0) begin
      tests_failed++; $display("FAIL wait_clear got v%b led %h want 0 000", led_valid, random_led);
    end
    tick();
    tests_run++;
    if (led_valid !== 1'b1) begin tests_failed++; $display("FAIL first_valid got %b want 1", led_valid); end
    tests_run++;
    if (random_led !== 10'h002) begin tests_failed++; $display("FAIL first_target got %h want 002", random_led); end
    tests_run++;
    if ($countones(random_led) !== 1) begin tests_failed++; $display("FAIL first_onehot got %h", random_led); end
    tests_run++;
    if (hit !== 1'b0 || timeout !== 1'b0 || round_cnt !== 4'd0) begin
      tests_failed++; $display("FAIL first_flags got h%b t%b r%0d want 0 0 0", hit, timeout, round_cnt);
    end
    prev_target = 10'h002;
  endtask

  // Match at edge 5; gap edges 6,7; next target at edge 8 from lfsr 0x2F1: idx0 1 == prev -> idx 2.
  task automatic test_hit();
    tick();
    tick();
    SPDTs = 10'h002;
    tick();
    tests_run++;
    if (hit !== 1'b1) begin tests_failed++; $display("FAIL hit_pulse got %b want 1", hit); end
    tests_run++;
    if (random_led !== 10'd0 || led_valid !== 1'b0) begin
      tests_failed++; $display("FAIL hit_blank got led %h v%b want 000 0", random_led, led_valid);
    end
    tests_run++;
    if (round_cnt !== 4'd1 || timeout !== 1'b0) begin
      tests_failed++; $display("FAIL hit_rounds got r%0d t%b want 1 0", round_cnt, timeout);
    end
    SPDTs = 10'd0;
    tick();
    tests_run++;
    if (hit !== 1'b0 || random_led !== 10'd0) begin
      tests_failed++; $display("FAIL hit_width got h%b led %h want 0 000", hit, random_led);
    end
    tick();
    tests_run++;
    if (random_led !== 10'd0 || led_valid !== 1'b0) begin
      tests_failed++; $display("FAIL gap_blank got led %h v%b want 000 0", random_led, led_valid);
    end
    tick();
    tests_run++;
    if (random_led !== 10'h004 || led_valid !== 1'b1) begin
      tests_failed++; $display("FAIL second_target got led %h v%b want 004 1", random_led, led_valid);
    end
    tests_run++;
    if (random_led === prev_target) begin tests_failed++; $display("FAIL second_differs got %h prev %h", random_led, prev_target); end
    prev_target = 10'h004;
    exp_rounds  = 4'd1;
  endtask

  // Wrong switch held: no hit, timeout on the 8th SHOW edge, then stuck in WAIT_CLEAR until cleared.
  task automatic test_timeout();
    SPDTs = 10'h001;
    for (int i = 0; i < 7; i++) begin
      tick();
      tests_run++;
      if (hit !== 1'b0 || timeout !== 1'b0 || led_valid !== 1'b1) begin
        tests_failed++; $display("FAIL show_hold[%0d] got h%b t%b v%b want 0 0 1", i, hit, timeout, led_valid);
      end
    end
    tick();
    tests_run++;
    if (timeout !== 1'b1 || hit !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_pulse got t%b h%b want 1 0", timeout, hit);
    end
    tests_run++;
    if (round_cnt !== 4'd2 || random_led !== 10'd0) begin
      tests_failed++; $display("FAIL timeout_rounds got r%0d led %h want 2 000", round_cnt, random_led);
    end
    tick();
    tests_run++;
    if (timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_width got %b want 0", timeout); end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (led_valid !== 1'b0 || random_led !== 10'd0 || hit !== 1'b0) begin
        tests_failed++; $display("FAIL clear_wait[%0d] got v%b led %h h%b want 0 000 0", i, led_valid, random_led, hit);
      end
    end
    SPDTs = 10'd0;
    tick();
    tests_run++;
    if (led_valid !== 1'b1 || $countones(random_led) !== 1) begin
      tests_failed++; $display("FAIL after_clear got v%b led %h want 1 onehot", led_valid, random_led);
    end
    tests_run++;
    if (random_led === prev_target) begin tests_failed++; $display("FAIL after_clear_differs got %h prev %h", random_led, prev_target); end
    prev_target = random_led;
    exp_rounds  = 4'd2;
  endtask

  // Hit, then keep the switch up through the gap: no new target until switches drop.
  task automatic test_back_to_back();
    SPDTs = prev_target;
    tick();
    tests_run++;
    if (hit !== 1'b1 || round_cnt !== 4'd3) begin
      tests_failed++; $display("FAIL b2b_hit got h%b r%0d want 1 3", hit, round_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      tests_run++;
      if (led_valid !== 1'b0 || random_led !== 10'd0) begin
        tests_failed++; $display("FAIL b2b_hold[%0d] got v%b led %h want 0 000", i, led_valid, random_led);
      end
    end
    SPDTs = 10'd0;
    tick();
    tests_run++;
    if (led_valid !== 1'b1 || $countones(random_led) !== 1) begin
      tests_failed++; $display("FAIL b2b_next got v%b led %h want 1 onehot", led_valid, random_led);
    end
    tests_run++;
    if (random_led === prev_target) begin tests_failed++; $display("FAIL b2b_differs got %h prev %h", random_led, prev_target); end
    prev_target = random_led;
    exp_rounds  = 4'd3;
  endtask

  // Leaving minigame overrides a simultaneous match; re-entry clears round_cnt.
  task automatic test_abort();
    tick();
    alarm_state = 3'b100;
    SPDTs       = prev_target;
    tick();
    tests_run++;
    if (random_led !== 10'd0 || led_valid !== 1'b0) begin
      tests_failed++; $display("FAIL abort_blank got led %h v%b want 000 0", random_led, led_valid);
    end
    tests_run++;
    if (hit !== 1'b0 || timeout !== 1'b0) begin
      tests_failed++; $display("FAIL abort_pulse got h%b t%b want 0 0", hit, timeout);
    end
    tests_run++;
    if (round_cnt !== exp_rounds) begin tests_failed++; $display("FAIL abort_rounds got %0d want %0d", round_cnt, exp_rounds); end
    SPDTs = 10'd0;
    repeat (3) tick();
    tests_run++;
    if (led_valid !== 1'b0 || round_cnt !== exp_rounds) begin
      tests_failed++; $display("FAIL abort_idle got v%b r%0d want 0 %0d", led_valid, round_cnt, exp_rounds);
    end
    alarm_state = 3'b010;
    tick();
    tests_run++;
    if (round_cnt !== 4'd0 || led_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reenter_clear got r%0d v%b want 0 0", round_cnt, led_valid);
    end
    tick();
    tests_run++;
    if (led_valid !== 1'b1 || $countones(random_led) !== 1) begin
      tests_failed++; $display("FAIL reenter_target got v%b led %h want 1 onehot", led_valid, random_led);
    end
    exp_rounds = 4'd0;
  endtask

  task automatic test_saturation();
    for (int r = 1; r <= 20; r++) begin
      int n;
      n = 0;
      while (led_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      tests_run++;
      if (led_valid !== 1'b1) begin
        tests_failed++; $display("FAIL sat_wait[%0d] got valid %b after %0d cycles want 1", r, led_valid, n);
      end
      tests_run++;
      if ($countones(random_led) !== 1) begin tests_failed++; $display("FAIL sat_onehot[%0d] got %h", r, random_led); end
      if (r > 1) begin
        tests_run++;
        if (random_led === prev_target) begin
          tests_failed++; $display("FAIL sat_differs[%0d] got %h prev %h", r, random_led, prev_target);
        end
      end
      prev_target = random_led;
      SPDTs       = random_led;
      tick();
      exp_rounds = (exp_rounds == 4'hF) ? 4'hF : exp_rounds + 4'd1;
      tests_run++;
      if (hit !== 1'b1) begin tests_failed++; $display("FAIL sat_hit[%0d] got %b want 1", r, hit); end
      tests_run++;
      if (round_cnt !== exp_rounds) begin
        tests_failed++; $display("FAIL sat_rounds[%0d] got %0d want %0d", r, round_cnt, exp_rounds);
      end
      SPDTs = 10'd0;
    end
  endtask

  initial begin
    test_reset();
    test_first_target();
    test_hit();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
